// File: rtl/tx_desc_sched.sv
// rtl/tx_desc_sched.sv - multi-queue TX descriptor fetch / write-back scheduler
//
// Purpose: for NQ transmit rings, decides when to fetch descriptors from the
// host ring and when to write completed ones back. Queues are picked
// round-robin, and write-back wins over fetch within a queue. One command at
// a time goes to the DMA command engine. The scheduler keeps a fetch pointer
// and a write-back pointer (head) for each queue.
//
// Ports:
//   aclk, aresetn        clock, asynchronous active-low reset
//   q_en                 per-queue transmit enable
//   q_tdt, q_len         per-queue host tail index and ring size (packed)
//   q_in_lvl, q_out_lvl  per-queue cached / completed descriptor levels
//   PTHRESH, HTHRESH     prefetch and host-available thresholds
//   WTHRESH              write-back threshold (0 = timer only)
//   TIDV, tick           write-back flush delay (0 = off) and its time base
//   cmd_valid/cmd_ready  command handshake; cmd_wb, cmd_q, cmd_idx, cmd_cnt
//   cmd_done             completion pulse for the outstanding command
//   q_tdh                per-queue head (write-back pointer), packed
module tx_desc_sched #(
  parameter int NQ    = 2,
  parameter int PTR_W = 16,
  parameter int LVL_W = 6,
  parameter int DEPTH = 32,
  parameter int TMO_W = 16
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [NQ-1:0]       q_en,
  input  logic [NQ*PTR_W-1:0] q_tdt,
  input  logic [NQ*PTR_W-1:0] q_len,
  input  logic [NQ*LVL_W-1:0] q_in_lvl,
  input  logic [NQ*LVL_W-1:0] q_out_lvl,
  input  logic [LVL_W-1:0]    PTHRESH,
  input  logic [LVL_W-1:0]    HTHRESH,
  input  logic [LVL_W-1:0]    WTHRESH,
  input  logic [TMO_W-1:0]    TIDV,
  input  logic                tick,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic                cmd_wb,
  output logic [2:0]          cmd_q,
  output logic [PTR_W-1:0]    cmd_idx,
  output logic [LVL_W-1:0]    cmd_cnt,
  input  logic                cmd_done,
  output logic [NQ*PTR_W-1:0] q_tdh
);

  // Wide enough for any pointer/level sum without overflow.
  localparam int CW = ((PTR_W > LVL_W) ? PTR_W : LVL_W) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] LVL_MAX = CW'((1 << LVL_W) - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARB   = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [2:0]       rr_q, rr_d;
  logic             cmd_wb_q;
  logic [2:0]       cmd_q_q;
  logic [PTR_W-1:0] cmd_idx_q;
  logic [LVL_W-1:0] cmd_cnt_q;

  logic [PTR_W-1:0] fp_q  [NQ];
  logic [PTR_W-1:0] fp_d  [NQ];
  logic [PTR_W-1:0] wp_q  [NQ];
  logic [PTR_W-1:0] wp_d  [NQ];
  logic [TMO_W-1:0] tmr_q [NQ];
  logic [TMO_W-1:0] tmr_d [NQ];

  logic [NQ-1:0]    f_ok, w_ok;
  logic [LVL_W-1:0] f_cnt [NQ];
  logic [LVL_W-1:0] w_cnt [NQ];

  logic             sel_found, sel_wb, load, hs;
  logic [2:0]       sel_q;
  logic [PTR_W-1:0] sel_idx;
  logic [LVL_W-1:0] sel_cnt;
  logic [CW-1:0]    hth;

  function automatic logic [CW-1:0] min2(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Advance a ring pointer; landing exactly on the ring size wraps to 0.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p,
                                                input logic [LVL_W-1:0] c,
                                                input logic [PTR_W-1:0] l);
    logic [CW-1:0] s;
    s = CW'(p) + CW'(c);
    return (s >= CW'(l)) ? '0 : PTR_W'(s);
  endfunction

  // A host threshold of 0 still needs at least one descriptor available.
  assign hth = (HTHRESH == '0) ? CW'(1) : CW'(HTHRESH);

  for (genvar g = 0; g < NQ; g++) begin : g_q
    logic [CW-1:0] tdt, len, fp, wp, inl, outl;
    logic [CW-1:0] avail, room, f_wrap, w_wrap, fmin, wmin;
    logic          expired;

    assign tdt  = CW'(q_tdt[g*PTR_W +: PTR_W]);
    assign len  = CW'(q_len[g*PTR_W +: PTR_W]);
    assign inl  = CW'(q_in_lvl[g*LVL_W +: LVL_W]);
    assign outl = CW'(q_out_lvl[g*LVL_W +: LVL_W]);
    assign fp   = CW'(fp_q[g]);
    assign wp   = CW'(wp_q[g]);

    assign avail  = (tdt >= fp) ? tdt - fp : tdt + len - fp;
    assign room   = (inl >= DEPTH_C) ? '0 : DEPTH_C - inl;
    // Commands never cross the ring end; the remainder goes in a second command.
    assign f_wrap = (fp >= len) ? '0 : len - fp;
    assign w_wrap = (wp >= len) ? '0 : len - wp;
    assign fmin   = min2(min2(avail, room), f_wrap);
    assign wmin   = min2(outl, w_wrap);

    assign f_cnt[g] = (fmin > LVL_MAX) ? '1 : LVL_W'(fmin);
    assign w_cnt[g] = (wmin > LVL_MAX) ? '1 : LVL_W'(wmin);

    assign expired = (TIDV != '0) && (tmr_q[g] >= TIDV);
    assign f_ok[g] = q_en[g] && (inl < CW'(PTHRESH)) && (avail >= hth) && (fmin != '0);
    assign w_ok[g] = q_en[g] && (outl != '0) && (wmin != '0) &&
                     (((WTHRESH != '0) && (outl >= CW'(WTHRESH))) || expired);

    assign q_tdh[g*PTR_W +: PTR_W] = wp_q[g];
  end

  // Round-robin pick: the eligible queue with the smallest distance from rr.
  always_comb begin
    int d, best_d;
    d         = 0;
    best_d    = NQ;
    sel_found = 1'b0;
    sel_q     = '0;
    sel_wb    = 1'b0;
    sel_idx   = '0;
    sel_cnt   = '0;
    for (int q = 0; q < NQ; q++) begin
      d = (q >= int'(rr_q)) ? q - int'(rr_q) : q + NQ - int'(rr_q);
      if ((f_ok[q] || w_ok[q]) && (d < best_d)) begin
        best_d    = d;
        sel_found = 1'b1;
        sel_q     = 3'(q);
        sel_wb    = w_ok[q];
        sel_idx   = w_ok[q] ? wp_q[q] : fp_q[q];
        sel_cnt   = w_ok[q] ? w_cnt[q] : f_cnt[q];
      end
    end
  end

  assign hs = (state_q == S_ISSUE) && cmd_ready;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE:  if (|q_en) state_d = S_ARB;
      S_ARB: begin
        if (sel_found) begin
          load    = 1'b1;
          state_d = S_ISSUE;
        end else if (!(|q_en)) begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (cmd_ready) begin
          rr_d    = (cmd_q_q >= 3'(NQ - 1)) ? 3'd0 : cmd_q_q + 3'd1;
          state_d = S_WAIT;
        end
      end
      S_WAIT:  if (cmd_done) state_d = S_ARB;
      default: state_d = S_IDLE;
    endcase
  end

  // Per-queue pointers and timers. A disabled queue is held cleared, which
  // also discards the pointer update of a command accepted after disable.
  always_comb begin
    logic hit;
    hit = 1'b0;
    for (int q = 0; q < NQ; q++) begin
      fp_d[q]  = fp_q[q];
      wp_d[q]  = wp_q[q];
      tmr_d[q] = tmr_q[q];
      hit      = hs && (cmd_q_q == 3'(q));
      if (!q_en[q]) begin
        fp_d[q]  = '0;
        wp_d[q]  = '0;
        tmr_d[q] = '0;
      end else begin
        if (hit && !cmd_wb_q) fp_d[q] = wrap_add(fp_q[q], cmd_cnt_q, q_len[q*PTR_W +: PTR_W]);
        if (hit && cmd_wb_q)  wp_d[q] = wrap_add(wp_q[q], cmd_cnt_q, q_len[q*PTR_W +: PTR_W]);
        // Clear outranks a coincident tick.
        if ((q_out_lvl[q*LVL_W +: LVL_W] == '0) || (TIDV == '0) || (hit && cmd_wb_q))
          tmr_d[q] = '0;
        else if (tick && (tmr_q[q] != '1))
          tmr_d[q] = tmr_q[q] + TMO_W'(1);
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      rr_q      <= '0;
      cmd_wb_q  <= 1'b0;
      cmd_q_q   <= '0;
      cmd_idx_q <= '0;
      cmd_cnt_q <= '0;
      for (int q = 0; q < NQ; q++) begin
        fp_q[q]  <= '0;
        wp_q[q]  <= '0;
        tmr_q[q] <= '0;
      end
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      if (load) begin
        cmd_wb_q  <= sel_wb;
        cmd_q_q   <= sel_q;
        cmd_idx_q <= sel_idx;
        cmd_cnt_q <= sel_cnt;
      end
      for (int q = 0; q < NQ; q++) begin
        fp_q[q]  <= fp_d[q];
        wp_q[q]  <= wp_d[q];
        tmr_q[q] <= tmr_d[q];
      end
    end
  end

  assign cmd_valid = (state_q == S_ISSUE);
  assign cmd_wb    = cmd_wb_q;
  assign cmd_q     = cmd_q_q;
  assign cmd_idx   = cmd_idx_q;
  assign cmd_cnt   = cmd_cnt_q;

endmodule
